// File: rtl/dot.sv
// dot: pipelined 3-element fixed-point dot product with a credit-controlled show-ahead output FIFO.
// Optional macro DOT_SATURATE_EN clamps results to the 32-bit range instead of wrapping.
module dot #(
    parameter int FIFO_BUFFER_SIZE = 16,
    parameter int QUANT = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [31:0] x [3],
    input  logic signed [31:0] y [3],
    input  logic               in_empty,
    output logic               in_rd_en,
    output logic signed [31:0] out,
    output logic               out_empty,
    input  logic               out_rd_en
);
    localparam int AW = $clog2(FIFO_BUFFER_SIZE);
    localparam logic [AW:0] DEPTH = FIFO_BUFFER_SIZE[AW:0];

    logic signed [63:0] p_q [3];
    logic signed [63:0] p_d [3];
    logic               v1_q, v1_d, v2_q, v2_d;
    logic signed [65:0] s_q, s_d;
    logic [AW-1:0]      wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]        cnt_q, cnt_d, used;
    logic [31:0]        mem_q [FIFO_BUFFER_SIZE];
    logic [31:0]        mem_d [FIFO_BUFFER_SIZE];
    logic [31:0]        res;
    logic               wr, rd;

    // Every popped vector holds a FIFO slot until it is written, so nothing is ever dropped.
    always_comb begin
        used     = cnt_q + (AW+1)'(v1_q) + (AW+1)'(v2_q);
        in_rd_en = !reset && !in_empty && (used < DEPTH);
        out_empty = (cnt_q == '0);
        out      = out_empty ? 32'sd0 : mem_q[rp_q];
        for (int i = 0; i < 3; i++)
            p_d[i] = in_rd_en ? 64'(x[i]) * 64'(y[i]) : p_q[i];
        v1_d = in_rd_en;
        s_d  = v1_q ? (66'(p_q[0]) + 66'(p_q[1]) + 66'(p_q[2])) >>> QUANT : s_q;
        v2_d = v1_q;
    end

`ifdef DOT_SATURATE_EN
    logic [34:0] hi;
    always_comb begin
        hi  = s_q[65:31];
        res = (&hi || ~|hi) ? s_q[31:0] : (s_q[65] ? 32'h8000_0000 : 32'h7FFF_FFFF);
    end
`else
    logic unused_hi;
    always_comb begin
        unused_hi = ^s_q[65:32];
        res = s_q[31:0];
    end
`endif

    always_comb begin
        wr    = v2_q;
        rd    = out_rd_en && !out_empty;
        mem_d = mem_q;
        if (wr)
            mem_d[wp_q] = res;
        wp_d  = wp_q + AW'(wr);
        rp_d  = rp_q + AW'(rd);
        cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end

    always_ff @(posedge clock) begin
        p_q   <= p_d;
        s_q   <= s_d;
        mem_q <= mem_d;
        if (reset) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_dot.sv
// tb_dot: directed table vectors plus streaming, backpressure and reset sequences for dot.
module tb_dot;
    localparam int N = 16;
    localparam int Q = 16;

    logic clock = 1'b0, reset = 1'b1, in_empty = 1'b1, out_rd_en = 1'b0;
    logic in_rd_en, out_empty;
    logic signed [31:0] x [3];
    logic signed [31:0] y [3];
    logic signed [31:0] out;

    dot #(.FIFO_BUFFER_SIZE(N), .QUANT(Q)) dut (
        .clock(clock), .reset(reset), .x(x), .y(y), .in_empty(in_empty),
        .in_rd_en(in_rd_en), .out(out), .out_empty(out_empty), .out_rd_en(out_rd_en)
    );

    always #5 clock = ~clock;

    int n_vec = 0, n_bad = 0;
    int k, total, got;
    logic signed [31:0] sx [1024][3];
    logic signed [31:0] sy [1024][3];
    logic [31:0] q [$];

    typedef struct {
        logic [31:0] x0, x1, x2, y0, y1, y2, e;
        string name;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic signed [31:0] a [3], input logic signed [31:0] b [3]);
        logic signed [127:0] s;
        longint p;
        s = '0;
        for (int i = 0; i < 3; i++) begin
            p = longint'(a[i]) * longint'(b[i]);
            s = s + {{64{p[63]}}, p};
        end
        s = s >>> Q;
`ifdef DOT_SATURATE_EN
        if (s > 128'sh7FFF_FFFF) s = 128'sh7FFF_FFFF;
        if (s < -128'sh8000_0000) s = -128'sh8000_0000;
`endif
        return s[31:0];
    endfunction

    task automatic send(input logic [31:0] a0, a1, a2, b0, b1, b2, output int lat);
        x[0] = a0; x[1] = a1; x[2] = a2;
        y[0] = b0; y[1] = b1; y[2] = b2;
        in_empty = 1'b0;
        #1;
        chk("in_rd_en ready", {31'b0, in_rd_en}, 32'd1);
        @(posedge clock); #1;
        in_empty = 1'b1;
        lat = 1;
        while (out_empty && lat < 10) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic pop_one();
        out_rd_en = 1'b1;
        @(posedge clock); #1;
        out_rd_en = 1'b0;
    endtask

    // One cycle of the streaming harness; q holds expected results in pop order.
    task automatic cyc(input bit stall, input bit rd);
        bit took, pop;
        in_empty = stall || (k >= total);
        if (k < total) begin
            x = sx[k];
            y = sy[k];
        end
        out_rd_en = rd;
        #1;
        took = rd && !out_empty;
        pop  = in_rd_en;
        if (took) begin
            if (q.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL stale result: got %h want none", out);
            end else
                chk("stream result", out, q[0]);
        end
        @(posedge clock);
        if (took) begin
            got++;
            if (q.size() > 0) void'(q.pop_front());
        end
        if (pop) begin
            q.push_back(model(sx[k], sy[k]));
            k++;
        end
        #1;
    endtask

    task automatic drain(input int bound, input bit rnd);
        int c = 0;
        while ((k < total || q.size() != 0) && c < bound) begin
            if (rnd) cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
            else cyc(1'b0, 1'b1);
            c++;
        end
        chk("drain complete", {31'b0, (k >= total && q.size() == 0)}, 32'd1);
        out_rd_en = 1'b0;
        in_empty = 1'b1;
    endtask

    task automatic ramp(input int n);
        for (int i = 0; i < n; i++) begin
            sx[i][0] = (i + 1) << 16; sx[i][1] = 0; sx[i][2] = 0;
            sy[i][0] = 32'h0001_0000; sy[i][1] = 0; sy[i][2] = 0;
        end
        total = n; k = 0; got = 0; q.delete();
    endtask

    initial begin
        int lat, cnt;
        for (int i = 0; i < 3; i++) begin x[i] = 0; y[i] = 0; end
        tbl[0] = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 32'h0005_0000, 32'h0006_0000, 32'h0020_0000, "basic"};
        tbl[1] = '{32'hFFFF_0000, 0, 0, 32'h0000_8000, 0, 0, 32'hFFFF_8000, "neg half"};
        tbl[2] = '{32'h0000_0001, 0, 0, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, "trunc floor"};
        tbl[3] = '{32'h0002_0000, 32'hFFFE_0000, 32'h0000_8000, 32'h0003_0000, 32'h0001_0000, 32'h0002_0000, 32'h0005_0000, "mixed"};
        tbl[4] = '{32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, 0, 0, 32'h0000_0000, "tiny pos"};
        tbl[5] = '{32'h8000_0000, 0, 0, 32'h0001_0000, 0, 0, 32'h8000_0000, "min exact"};
`ifdef DOT_SATURATE_EN
        tbl[6] = '{32'h7FFF_0000, 32'h7FFF_0000, 0, 32'h7FFF_0000, 32'h7FFF_0000, 0, 32'h7FFF_FFFF, "overflow"};
        tbl[7] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, "wide sum"};
`else
        tbl[6] = '{32'h7FFF_0000, 32'h7FFF_0000, 0, 32'h7FFF_0000, 32'h7FFF_0000, 0, 32'h0002_0000, "overflow"};
        tbl[7] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, "wide sum"};
`endif

        in_empty = 1'b0;
        @(posedge clock); #1;
        chk("rd_en in reset", {31'b0, in_rd_en}, 32'd0);
        @(posedge clock); #1;
        chk("reset out_empty", {31'b0, out_empty}, 32'd1);
        chk("reset out", out, 32'd0);
        reset = 1'b0;
        in_empty = 1'b1;

        // Pop attempts on an empty FIFO must not disturb state.
        out_rd_en = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        out_rd_en = 1'b0;
        chk("empty pop ignored", {31'b0, out_empty}, 32'd1);

        foreach (tbl[i]) begin
            send(tbl[i].x0, tbl[i].x1, tbl[i].x2, tbl[i].y0, tbl[i].y1, tbl[i].y2, lat);
            chk({tbl[i].name, " latency"}, lat, 32'd3);
            chk(tbl[i].name, out, tbl[i].e);
            pop_one();
            chk({tbl[i].name, " empty after pop"}, {31'b0, out_empty}, 32'd1);
        end

        // Backpressure: only FIFO_BUFFER_SIZE vectors may be accepted while nothing drains.
        ramp(20);
        repeat (40) cyc(1'b0, 1'b0);
        chk("bp accepted", k, 32'd16);
        chk("bp rd_en held", {31'b0, in_rd_en}, 32'd0);
        chk("bp stored", q.size(), 32'd16);
        drain(200, 1'b0);
        chk("bp results", got, 32'd20);

        // Throughput with no stalls.
        for (int i = 0; i < 200; i++)
            for (int j = 0; j < 3; j++) begin sx[i][j] = $urandom; sy[i][j] = $urandom; end
        total = 200; k = 0; got = 0; q.delete();
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            cyc(1'b0, 1'b1);
            if (c == 4) cnt = got;
        end
        chk("throughput", got - cnt, 32'd195);
        drain(100, 1'b0);

        // Random streaming with toggled stalls.
        for (int i = 0; i < 1024; i++)
            for (int j = 0; j < 3; j++) begin sx[i][j] = $urandom; sy[i][j] = $urandom; end
        total = 1024; k = 0; got = 0; q.delete();
        drain(20000, 1'b1);
        chk("stream count", got, 32'd1024);

        // Reset mid-stream with 5 stored and 2 in flight.
        ramp(7);
        repeat (7) cyc(1'b0, 1'b0);
        chk("pre-reset pops", k, 32'd7);
        chk("pre-reset nonempty", {31'b0, out_empty}, 32'd0);
        reset = 1'b1;
        in_empty = 1'b0;
        #1;
        chk("rd_en during reset", {31'b0, in_rd_en}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        in_empty = 1'b1;
        chk("mid reset out_empty", {31'b0, out_empty}, 32'd1);
        chk("mid reset out", out, 32'd0);
        cnt = 0;
        repeat (5) begin
            @(posedge clock); #1;
            if (!out_empty) cnt++;
        end
        chk("no stale results", cnt, 32'd0);
        send(32'h0003_0000, 0, 0, 32'h0002_0000, 0, 0, lat);
        chk("post reset latency", lat, 32'd3);
        chk("post reset result", out, 32'h0006_0000);
        pop_one();
        chk("post reset drained", {31'b0, out_empty}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
